// File: rtl/display_pkg.sv
// Shared constants for the 7-segment scan driver: digit code width and
// active-high segment glyphs (bit6=a ... bit0=g).
package display_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [6:0] SEG_0        = 7'b1111110;
    localparam logic [6:0] SEG_1        = 7'b0110000;
    localparam logic [6:0] SEG_2        = 7'b1101101;
    localparam logic [6:0] SEG_3        = 7'b1111001;
    localparam logic [6:0] SEG_4        = 7'b0110011;
    localparam logic [6:0] SEG_5        = 7'b1011011;
    localparam logic [6:0] SEG_6        = 7'b1011111;
    localparam logic [6:0] SEG_7        = 7'b1110000;
    localparam logic [6:0] SEG_8        = 7'b1111111;
    localparam logic [6:0] SEG_9        = 7'b1111011;
    localparam logic [6:0] SEG_6_NOTAIL = 7'b0011111;
    localparam logic [6:0] SEG_9_NOTAIL = 7'b1110011;
    localparam logic [6:0] SEG_A        = 7'b1110111;
    localparam logic [6:0] SEG_B        = 7'b0011111;
    localparam logic [6:0] SEG_C        = 7'b1001110;
    localparam logic [6:0] SEG_D        = 7'b0111101;
    localparam logic [6:0] SEG_E        = 7'b1001111;
    localparam logic [6:0] SEG_F        = 7'b1000111;
    localparam logic [6:0] SEG_OFF      = 7'b0000000;

endpackage

// File: rtl/seg7_decode.sv
// Combinational digit-code to active-high 7-segment pattern decoder with
// optional hex glyphs, selectable 6/9 tails and a blanking input.
module seg7_decode
    import display_pkg::*;
#(
    parameter int HEX_EN = 0,
    parameter int TAILS  = 1
) (
    input  logic [DIGIT_W-1:0] code,
    input  logic               suppress,
    output logic [6:0]         pattern
);

    always_comb begin
        pattern = SEG_OFF;
        case (code)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = (TAILS != 0) ? SEG_6 : SEG_6_NOTAIL;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = (TAILS != 0) ? SEG_9 : SEG_9_NOTAIL;
            4'd10:   pattern = (HEX_EN != 0) ? SEG_A : SEG_OFF;
            4'd11:   pattern = (HEX_EN != 0) ? SEG_B : SEG_OFF;
            4'd12:   pattern = (HEX_EN != 0) ? SEG_C : SEG_OFF;
            4'd13:   pattern = (HEX_EN != 0) ? SEG_D : SEG_OFF;
            4'd14:   pattern = (HEX_EN != 0) ? SEG_E : SEG_OFF;
            default: pattern = (HEX_EN != 0) ? SEG_F : SEG_OFF;
        endcase
        if (suppress) pattern = SEG_OFF;
    end

endmodule

// File: rtl/display_scan_mux.sv
// Time-multiplexed N-digit 7-segment driver: prescaled digit scan, frame-
// synchronous value capture, leading-zero blanking and pin polarity control.
module display_scan_mux
    import display_pkg::*;
#(
    parameter int N_DIGITS    = 6,
    parameter int DIV         = 50000,
    parameter int HEX_EN      = 0,
    parameter int TAILS       = 1,
    parameter int SEG_ACT_LOW = 0,
    parameter int AN_ACT_LOW  = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DIGIT_W*N_DIGITS-1:0] digits_in,
    input  logic [N_DIGITS-1:0]         dp_in,
    input  logic                        load,
    input  logic                        lz_en,
    input  logic                        blank,
    output logic [6:0]                  seg_out,
    output logic                        dp_out,
    output logic [N_DIGITS-1:0]         an_out,
    output logic                        frame_start
);

    localparam int IDX_W = $clog2(N_DIGITS);
    localparam int CNT_W = $clog2(DIV);
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(N_DIGITS - 1);
    localparam logic [CNT_W-1:0]    LAST_CNT = CNT_W'(DIV - 1);
    localparam logic [6:0]          SEG_MASK = (SEG_ACT_LOW != 0) ? 7'h7f : 7'h00;
    localparam logic                DP_MASK  = (SEG_ACT_LOW != 0);
    localparam logic [N_DIGITS-1:0] AN_MASK  = (AN_ACT_LOW != 0) ? {N_DIGITS{1'b1}} : '0;

    logic [CNT_W-1:0]              cnt;
    logic                          tick;
    logic                          tick_p1;
    logic                          run;
    logic                          wrap;
    logic [IDX_W-1:0]              idx;
    logic                          pending;
    logic [DIGIT_W*N_DIGITS-1:0]   staging;
    logic [N_DIGITS-1:0]           staging_dp;
    logic [DIGIT_W*N_DIGITS-1:0]   shadow;
    logic [N_DIGITS-1:0]           shadow_dp;
    logic [DIGIT_W-1:0]            cur_code;
    logic                          suppress;
    logic [6:0]                    pattern;
    logic [N_DIGITS-1:0]           an_sel;

    assign tick = (cnt == LAST_CNT);
    // The first tick after reset only starts the scan, so digit 0 gets a full slot.
    assign wrap = tick && run && (idx == LAST_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            tick_p1   <= 1'b0;
            run       <= 1'b0;
            idx       <= '0;
            pending   <= 1'b0;
            shadow    <= '0;
            shadow_dp <= '0;
        end else begin
            cnt     <= tick ? '0 : cnt + CNT_W'(1);
            tick_p1 <= tick;
            if (tick) begin
                if (!run)
                    run <= 1'b1;
                else if (idx == LAST_IDX)
                    idx <= '0;
                else
                    idx <= idx + IDX_W'(1);
            end
            // A load on the wrap edge bypasses staging straight into shadow.
            if (wrap && (load || pending)) begin
                shadow    <= load ? digits_in : staging;
                shadow_dp <= load ? dp_in : staging_dp;
            end
            pending <= wrap ? 1'b0 : (pending || load);
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            staging    <= digits_in;
            staging_dp <= dp_in;
        end
    end

    assign cur_code = shadow[DIGIT_W*int'(idx) +: DIGIT_W];

    always_comb begin
        logic upper_zero;
        upper_zero = 1'b1;
        suppress   = 1'b0;
        for (int k = N_DIGITS - 1; k > 0; k--) begin
            upper_zero = upper_zero && (shadow[DIGIT_W*k +: DIGIT_W] == '0);
            if (int'(idx) == k) suppress = lz_en && upper_zero;
        end
    end

    seg7_decode #(
        .HEX_EN (HEX_EN),
        .TAILS  (TAILS)
    ) u_decode (
        .code     (cur_code),
        .suppress (suppress),
        .pattern  (pattern)
    );

    assign an_sel = (run && !blank) ? (N_DIGITS'(1) << idx) : '0;

    // Output stage: one cycle behind idx/shadow, polarity applied at the pins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_out     <= SEG_OFF ^ SEG_MASK;
            dp_out      <= DP_MASK;
            an_out      <= AN_MASK;
            frame_start <= 1'b0;
        end else begin
            seg_out     <= (run ? pattern : SEG_OFF) ^ SEG_MASK;
            dp_out      <= (run && shadow_dp[idx]) ^ DP_MASK;
            an_out      <= an_sel ^ AN_MASK;
            frame_start <= tick_p1 && run && (idx == '0);
        end
    end

endmodule

// File: tb/tb_display_scan_mux.sv
// Randomized bench for display_scan_mux: two configurations driven in parallel
// and compared every cycle against a cycle-count based reference model.
module tb_display_scan_mux;

    localparam int N   = 6;
    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] digits_in;
    logic [5:0]  dp_in;
    logic        load, lz_en, blank;
    logic [6:0]  seg_a, seg_b;
    logic        dp_a, dp_b, fs_a, fs_b;
    logic [5:0]  an_a, an_b;

    int vectors     = 0;
    int miscompares = 0;

    // Model state: edges since reset release, staged and displayed values.
    int          e;
    logic [23:0] stage, shad;
    logic [5:0]  stage_dp, shad_dp;
    bit          pend;

    always #5 clk = ~clk;

    display_scan_mux #(.N_DIGITS(N), .DIV(DIV), .HEX_EN(0), .TAILS(1),
                       .SEG_ACT_LOW(0), .AN_ACT_LOW(1)) dut_a (
        .clk(clk), .rst(rst), .digits_in(digits_in), .dp_in(dp_in), .load(load),
        .lz_en(lz_en), .blank(blank), .seg_out(seg_a), .dp_out(dp_a),
        .an_out(an_a), .frame_start(fs_a));

    display_scan_mux #(.N_DIGITS(N), .DIV(DIV), .HEX_EN(1), .TAILS(0),
                       .SEG_ACT_LOW(1), .AN_ACT_LOW(0)) dut_b (
        .clk(clk), .rst(rst), .digits_in(digits_in), .dp_in(dp_in), .load(load),
        .lz_en(lz_en), .blank(blank), .seg_out(seg_b), .dp_out(dp_b),
        .an_out(an_b), .frame_start(fs_b));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] code, input bit hex, input bit tails);
        case (code)
            4'd0:  return 7'b1111110;
            4'd1:  return 7'b0110000;
            4'd2:  return 7'b1101101;
            4'd3:  return 7'b1111001;
            4'd4:  return 7'b0110011;
            4'd5:  return 7'b1011011;
            4'd6:  return tails ? 7'b1011111 : 7'b0011111;
            4'd7:  return 7'b1110000;
            4'd8:  return 7'b1111111;
            4'd9:  return tails ? 7'b1111011 : 7'b1110011;
            4'd10: return hex ? 7'b1110111 : 7'b0;
            4'd11: return hex ? 7'b0011111 : 7'b0;
            4'd12: return hex ? 7'b1001110 : 7'b0;
            4'd13: return hex ? 7'b0111101 : 7'b0;
            4'd14: return hex ? 7'b1001111 : 7'b0;
            default: return hex ? 7'b1000111 : 7'b0;
        endcase
    endfunction

    // Edge ee is the tick that returns the scan from digit N-1 to digit 0.
    function automatic bit is_wrap(input int ee);
        return (ee % DIV == 0) && (ee / DIV >= 2) && ((ee / DIV - 1) % N == 0);
    endfunction

    function automatic void model_reset();
        e = 0; shad = '0; shad_dp = '0; pend = 0;
    endfunction

    // Called at a negedge; applies one clock of stimulus and checks both DUTs.
    task automatic step(input logic ld, input logic [23:0] d, input logic [5:0] dp,
                        input logic lz, input logic bl);
        int p, s;
        bit running, sup;
        logic [3:0] code;
        logic [5:0] an_act, an_exp_a;
        logic [6:0] seg_exp_a, seg_exp_b;
        logic dp_act, dp_exp_b, fs_exp;
        load = ld; digits_in = d; dp_in = dp; lz_en = lz; blank = bl;
        @(posedge clk);
        e++;
        p       = e - 1;
        running = (p >= DIV);
        s       = running ? ((p / DIV) - 1) % N : 0;
        code    = 4'(shad >> (4 * s));
        sup     = lz && (s > 0) && ((shad >> (4 * s)) == 24'd0);
        an_act  = (running && !bl) ? (6'd1 << s) : 6'd0;
        an_exp_a  = ~an_act;
        seg_exp_a = (running && !sup) ? glyph(code, 0, 1) : 7'd0;
        seg_exp_b = ~((running && !sup) ? glyph(code, 1, 0) : 7'd0);
        dp_act    = running && shad_dp[s];
        dp_exp_b  = ~dp_act;
        fs_exp    = running && (p % DIV == 0) && (s == 0);
        if (ld) begin
            stage = d; stage_dp = dp; pend = 1;
        end
        if (is_wrap(e) && pend) begin
            shad = stage; shad_dp = stage_dp; pend = 0;
        end
        #1;
        chk("an_a", an_a, an_exp_a);
        chk("seg_a", seg_a, seg_exp_a);
        chk("dp_a", dp_a, dp_act);
        chk("fs_a", fs_a, fs_exp);
        chk("an_b", an_b, an_act);
        chk("seg_b", seg_b, seg_exp_b);
        chk("dp_b", dp_b, dp_exp_b);
        chk("fs_b", fs_b, fs_exp);
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic [5:0] dp, input logic lz, input logic bl);
        for (int i = 0; i < n; i++) step(1'b0, 24'h0, dp, lz, bl);
    endtask

    task automatic check_reset_pins();
        chk("rst_an_a", an_a, 6'b111111);
        chk("rst_seg_a", seg_a, 7'b0000000);
        chk("rst_dp_a", dp_a, 1'b0);
        chk("rst_fs_a", fs_a, 1'b0);
        chk("rst_an_b", an_b, 6'b000000);
        chk("rst_seg_b", seg_b, 7'b1111111);
        chk("rst_dp_b", dp_b, 1'b1);
    endtask

    // Asserts reset between edges, checks the pins at once, releases at a negedge.
    task automatic async_reset();
        #2 rst = 1'b1; load = 1'b0;
        #1 check_reset_pins();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int n;
        rst = 1'b1; load = 0; digits_in = '0; dp_in = '0; lz_en = 0; blank = 0;
        #1 check_reset_pins();
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // First anode after reset release.
        n = 0;
        do begin
            step(1'b0, 24'h0, 6'h0, 1'b0, 1'b0);
            n++;
        end while (an_a === 6'b111111 && n < 20);
        chk("first_anode_lat", n, 5);
        chk("first_anode", an_a, 6'b111110);

        // Scan a known value for a few frames, then reset mid-count.
        step(1'b1, 24'h123456, 6'h0, 1'b0, 1'b0);
        idle(3 * N * DIV, 6'h0, 1'b0, 1'b0);
        idle(2, 6'h0, 1'b0, 1'b0);
        async_reset();
        step(1'b1, 24'h123456, 6'h0, 1'b0, 1'b0);
        idle(2 * N * DIV, 6'h0, 1'b0, 1'b0);

        // Mid-frame load must not tear the current frame.
        idle(2 * DIV + 1, 6'h0, 1'b0, 1'b0);
        step(1'b1, 24'h000042, 6'h0, 1'b0, 1'b0);
        idle(2 * N * DIV, 6'h0, 1'b0, 1'b0);

        // Leading-zero suppression.
        step(1'b1, 24'h000007, 6'h0, 1'b1, 1'b0);
        idle(2 * N * DIV, 6'h0, 1'b1, 1'b0);
        step(1'b1, 24'h000000, 6'h0, 1'b1, 1'b0);
        idle(2 * N * DIV, 6'h0, 1'b1, 1'b0);
        step(1'b1, 24'h090B00, 6'h0, 1'b1, 1'b0);
        idle(2 * N * DIV, 6'h0, 1'b1, 1'b0);

        // Glyph modes, decimal point and blanking.
        step(1'b1, 24'h9B9B9B, 6'b000100, 1'b0, 1'b0);
        idle(2 * N * DIV, 6'h0, 1'b0, 1'b0);
        step(1'b1, 24'hFEDCBA, 6'b000100, 1'b0, 1'b0);
        idle(N * DIV, 6'h0, 1'b0, 1'b1);
        idle(N * DIV, 6'h0, 1'b0, 1'b0);
        step(1'b1, 24'h876543, 6'b000100, 1'b1, 1'b0);
        idle(2 * N * DIV, 6'h0, 1'b0, 1'b0);

        // Load on the wrap edge itself, then two loads in one frame.
        for (int i = 0; i < 2 * N * DIV && !is_wrap(e + 1); i++) step(1'b0, 24'h0, 6'h0, 1'b0, 1'b0);
        step(1'b1, 24'h654321, 6'b100001, 1'b0, 1'b0);
        idle(N * DIV, 6'h0, 1'b0, 1'b0);
        step(1'b1, 24'h111111, 6'h0, 1'b0, 1'b0);
        idle(3, 6'h0, 1'b0, 1'b0);
        step(1'b1, 24'h000908, 6'h3f, 1'b1, 1'b0);
        idle(2 * N * DIV, 6'h0, 1'b1, 1'b0);

        // Randomized traffic with a reset in the middle.
        begin
            logic lz_r, bl_r;
            lz_r = 0; bl_r = 0;
            for (int i = 0; i < 1200; i++) begin
                if (i == 600) async_reset();
                if ($urandom_range(0, 39) == 0) lz_r = ~lz_r;
                if ($urandom_range(0, 49) == 0) bl_r = ~bl_r;
                if ($urandom_range(0, 11) == 0) begin
                    logic [23:0] d;
                    d = 24'($urandom);
                    if ($urandom_range(0, 2) == 0) d = d >> (4 * $urandom_range(1, 5));
                    step(1'b1, d, 6'($urandom), lz_r, bl_r);
                end else begin
                    step(1'b0, 24'($urandom), 6'($urandom), lz_r, bl_r);
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/display_scan_mux.md
Name: display_scan_mux

Overview:
- Time-multiplexed driver for an N-digit common-anode/cathode 7-segment display. Its decoded digit values come from the clock's BCD counters.
- Successor to the single-digit combinational BCD decoder: adds digit scanning, frame-synchronous value capture, leading-zero blanking, optional hex glyphs, decimal points and polarity control.
- Sits between the time-keeping counters and the board's seg/anode pins.

Parameters:
- N_DIGITS, 6, number of digits scanned (HH:MM:SS); legal range 2..8.
- DIV, 50000, clk cycles per digit slot; legal range >= 2.
- HEX_EN, 0, 1: codes 10..15 show A,b,C,d,E,F; 0: codes 10..15 blank.
- TAILS, 1, 1: draw segment a on 6 and segment d on 9; 0: tail-less 6 and 9.
- SEG_ACT_LOW, 0, 1: seg_out and dp_out are inverted at the pins.
- AN_ACT_LOW, 1, 1: an_out is active-low.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- digits_in  in  4*N_DIGITS  BCD/hex codes; digit k occupies bits [4k+3:4k]; k=0 is least significant
- dp_in  in  N_DIGITS  decimal point per digit
- load  in  1  request capture of digits_in/dp_in
- lz_en  in  1  leading-zero suppression enable
- blank  in  1  force all anodes inactive
- seg_out  out  7  segments, bit6=a ... bit0=g
- dp_out  out  1  decimal point of current digit
- an_out  out  N_DIGITS  one-hot anode select
- frame_start  out  1  one-cycle pulse when digit 0 becomes active

Behaviour:
- Reset (async, rst=1):
  - Prescaler=0, idx=0, shadow digits=0, shadow dp=0, pending=0.
  - seg_out, dp_out and an_out are all at their inactive level (polarity applied); frame_start=0.
- Prescaler:
  - Counts 0..DIV-1.
  - tick=1 in the cycle where it equals DIV-1, then it wraps to 0.
- Digit index:
  - On a clk edge with tick=1, idx increments.
  - When idx is N_DIGITS-1 it wraps to 0 instead.
- Capture:
  - load=1 at an edge copies digits_in/dp_in into a staging register and sets pending.
  - At a tick edge where idx wraps N_DIGITS-1 -> 0, pending=1 moves staging into shadow and clears pending.
  - Display content therefore only changes at frame boundaries; there is no tearing.
  - Multiple loads within one frame: the last one wins.
  - load coinciding with the wrap tick: staging takes the new value, and shadow also takes that same new value at that edge (bypass).
- Leading-zero suppression:
  - Digit k (k>0) is blanked when lz_en=1 and shadow digits N_DIGITS-1..k are all 0.
  - Digit 0 is never suppressed.
  - dp of a suppressed digit is still driven from shadow dp.
- Decode:
  - Codes 0..9 give the standard glyphs: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111 (TAILS=1) or 0011111 (TAILS=0), 7=1110000, 8=1111111, 9=1111011 (TAILS=1) or 1110011 (TAILS=0).
  - 10..15 per HEX_EN: A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111, or 0000000 when HEX_EN=0.
  - A suppressed digit gives 0000000.
- Output registers:
  - seg_out, dp_out and an_out are registered and reflect the new idx one clk after the tick edge; latency from tick to pins is 1 cycle.
  - an_out has exactly one active bit, at position idx, except when blank=1, when all anodes are inactive (blank is registered with the same 1-cycle latency).
  - frame_start=1 for exactly the cycle in which the outputs first show idx=0.
  - frame_start is not asserted on the first cycle after reset.
- Reset mid-frame: all state returns to reset values immediately; the scan restarts at idx=0 after DIV cycles.

Decomposition:
- Package display_pkg holds:
  - segment glyph constants (SEG_0..SEG_9, SEG_A..SEG_F, SEG_OFF);
  - the digit-code width constant DIGIT_W=4.
- Sub-module seg7_decode: combinational. Inputs: 4-bit code, suppress. Parameters: HEX_EN, TAILS. Output: active-high 7-bit pattern. display_scan_mux applies polarity afterwards.

Test Plan:
- Reset: rst=1 mid-count with DIV=4, N_DIGITS=6, AN_ACT_LOW=1 -> an_out=6'b111111 and seg_out=0 at once. After release, first active anode an_out=6'b111110 appears 5 cycles later.
- Scan and wrap: load 0x123456 -> over 24 cycles an_out walks digits 0..5. seg_out equals 6,5,4,3,2,1 glyphs in turn. frame_start pulses on each return to digit 0.
- Frame sync: load 0x000042 mid-frame while 0x123456 is displayed -> remaining digits of that frame still show 0x123456. New value appears from the next frame_start.
- Leading zeros: lz_en=1, value 0x000007 -> digits 5..1 show 0000000 and digit 0 shows 1110000. Value 0x000000 -> only digit 0 lit, showing 1111110.
- Glyph modes: code 9 with TAILS=0 -> 1110011; with TAILS=1 -> 1111011. Code 0xB with HEX_EN=1 -> 0011111; with HEX_EN=0 -> 0000000.
- Blank and dp: blank=1 -> all anodes inactive 1 cycle later while scanning continues. dp_in=6'b000100 -> dp_out active only while digit 2 is selected.
